mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between two requesters:
  - the fetch stage (instruction reads);
  - the memory stage (data loads/stores).
- One transaction outstanding at a time.
- Data requests win by default; an anti-starvation counter guarantees fetch progress.
- Produces per-requester stall signals that drive the PC-enable / NOP-insertion path, plus a sticky timeout error.

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and status signals of the fetch/data memory port arbiter.
// slave is the arbiter's view; master is the view of the surrounding pipeline and memory.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          if_stall;

  logic          d_req;
  logic          d_we;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          d_stall;

  logic          mem_req;
  logic          mem_we;
  logic [1:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  logic          timeout_err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_ack, mem_rdata,
    output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
           mem_req, mem_we, mem_size, mem_addr, mem_wdata, timeout_err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_ack, mem_rdata,
    input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
           mem_req, mem_we, mem_size, mem_addr, mem_wdata, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the data stage,
// one transaction at a time, data-first with a bounded fetch starvation window.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [7:0] TO_LIM     = 8'(TIMEOUT);

  state_t        state_q, state_d;
  logic [3:0]    starve_q;
  logic [7:0]    tcnt_q;
  logic          grant_if, grant_d, finish, abort;
  logic [AW-1:0] addr_sel;
  logic [DW-1:0] wdata_sel;
  logic          we_sel;
  logic [1:0]    size_sel;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_d  = 1'b0;
    finish   = 1'b0;
    abort    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // While a valid pulse is out, the finishing requester's req is stale, so no grant is made.
        if (!(bus.if_valid || bus.d_valid)) begin
          if (bus.d_req && !(bus.if_req && starve_q == STARVE_LIM)) grant_d  = 1'b1;
          else if (bus.if_req)                                      grant_if = 1'b1;
        end
        if (grant_d)       state_d = BUSY_D;
        else if (grant_if) state_d = BUSY_IF;
      end
      BUSY_IF, BUSY_D: begin
        finish = bus.mem_ack;
        abort  = !bus.mem_ack && (tcnt_q + 8'd1 == TO_LIM);
        if (finish || abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.if_stall = bus.if_req && !bus.if_valid;
    bus.d_stall  = bus.d_req && !bus.d_valid;
    if (grant_d) begin
      addr_sel  = bus.d_addr;
      wdata_sel = bus.d_wdata;
      we_sel    = bus.d_we;
      size_sel  = bus.d_size;
    end else begin
      addr_sel  = bus.if_addr;
      wdata_sel = bus.mem_wdata;
      we_sel    = 1'b0;
      size_sel  = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mem_req     <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_size    <= '0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.if_valid    <= 1'b0;
      bus.d_valid     <= 1'b0;
      bus.if_rdata    <= '0;
      bus.d_rdata     <= '0;
      bus.timeout_err <= 1'b0;
      starve_q        <= '0;
      tcnt_q          <= '0;
    end else begin
      bus.mem_req <= grant_if || grant_d;
      if (grant_if || grant_d) begin
        bus.mem_addr  <= addr_sel;
        bus.mem_we    <= we_sel;
        bus.mem_size  <= size_sel;
        bus.mem_wdata <= wdata_sel;
      end

      bus.if_valid <= (state_q == BUSY_IF) && (finish || abort);
      bus.d_valid  <= (state_q == BUSY_D)  && (finish || abort);

      if (state_q == BUSY_IF && finish)     bus.if_rdata <= bus.mem_rdata;
      else if (state_q == BUSY_IF && abort) bus.if_rdata <= '0;
      if (state_q == BUSY_D && finish)      bus.d_rdata  <= bus.mem_rdata;
      else if (state_q == BUSY_D && abort)  bus.d_rdata  <= '0;

      if (abort) bus.timeout_err <= 1'b1;

      tcnt_q <= (state_q != IDLE && !(finish || abort)) ? tcnt_q + 8'd1 : '0;

      if (grant_if) begin
        starve_q <= '0;
      end else if (grant_d && bus.if_req) begin
        if (starve_q < STARVE_LIM) starve_q <= starve_q + 4'd1;
      end else if (state_q == IDLE && !bus.if_req) begin
        starve_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic checked
// cycle by cycle against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;
  localparam int TO   = 64;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks;
  int failures;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  assert property (@(posedge clk) (!reset && bus.if_req && !bus.if_valid)
                   |=> (reset || (bus.if_req && $stable(bus.if_addr))))
    else $error("fetch requester changed address or dropped req while pending");
  assert property (@(posedge clk) (!reset && bus.d_req && !bus.d_valid)
                   |=> (reset || (bus.d_req && $stable(bus.d_addr))))
    else $error("data requester changed address or dropped req while pending");

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3C5A_0F96;
  endfunction

  // Randomized traffic knobs, requester/responder state and reference model
  int   p_if, p_d, max_k;
  bit   spur_en;
  bit   f_after, d_after, rsp_busy;
  int   rsp_left;
  int   m_busy;                 // 0 none, 1 fetch in flight, 2 data in flight
  bit   m_mreq, m_fv, m_dv, m_we, m_err;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  int   m_wins;                 // data grants since fetch started waiting
  bit   glog[$];                // observed grants, 1 = data

  task automatic drive_quiet();
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = '0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_mem_req"}, bus.mem_req, 0);
    check_eq({tag, "_mem_we"}, bus.mem_we, 0);
    check_eq({tag, "_mem_size"}, bus.mem_size, 0);
    check_eq({tag, "_mem_addr"}, bus.mem_addr, 0);
    check_eq({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    check_eq({tag, "_if_valid"}, bus.if_valid, 0);
    check_eq({tag, "_d_valid"}, bus.d_valid, 0);
    check_eq({tag, "_if_rdata"}, bus.if_rdata, 0);
    check_eq({tag, "_d_rdata"}, bus.d_rdata, 0);
    check_eq({tag, "_timeout_err"}, bus.timeout_err, 0);
  endtask

  task automatic engine_init(input bit err);
    f_after = 0; d_after = 0; rsp_busy = 0; rsp_left = 0;
    m_busy = 0; m_mreq = 0; m_fv = 0; m_dv = 0; m_wins = 0; m_err = err;
    m_we = 0; m_size = '0; m_addr = '0; m_wdata = '0;
  endtask

  task automatic engine_cycle();
    bit idle_now, nmreq, nfv, ndv;
    @(posedge clk); #1;
    if (bus.if_valid) f_after = 1'b1;
    else begin
      if (!bus.if_req || f_after) begin
        bus.if_req  = (int'($urandom_range(99)) < p_if);
        bus.if_addr = $urandom & 32'h0FFF_FFFC;
      end
      f_after = 1'b0;
    end
    if (bus.d_valid) d_after = 1'b1;
    else begin
      if (!bus.d_req || d_after) begin
        bus.d_req   = (int'($urandom_range(99)) < p_d);
        bus.d_we    = 1'($urandom_range(1));
        bus.d_size  = 2'($urandom_range(2));
        bus.d_addr  = $urandom | 32'h8000_0000;
        bus.d_wdata = $urandom;
      end
      d_after = 1'b0;
    end
    bus.mem_ack = 1'b0;
    if (bus.mem_req) begin
      rsp_busy = 1'b1;
      rsp_left = int'($urandom_range(max_k));
    end
    if (rsp_busy) begin
      if (rsp_left == 0) begin
        bus.mem_ack = 1'b1; bus.mem_rdata = mem_word(bus.mem_addr); rsp_busy = 1'b0;
      end else rsp_left--;
    end else if (spur_en && $urandom_range(9) == 0) begin
      bus.mem_ack = 1'b1; bus.mem_rdata = $urandom;
    end

    @(negedge clk);
    check_eq("mem_req", bus.mem_req, m_mreq);
    if (m_mreq) begin
      check_eq("mem_addr", bus.mem_addr, m_addr);
      check_eq("mem_we", bus.mem_we, m_we);
      check_eq("mem_size", bus.mem_size, m_size);
      if (m_we) check_eq("mem_wdata", bus.mem_wdata, m_wdata);
    end
    if (bus.mem_req) glog.push_back(bus.mem_addr[31]);
    check_eq("if_valid", bus.if_valid, m_fv);
    check_eq("d_valid", bus.d_valid, m_dv);
    if (m_fv) check_eq("if_rdata", bus.if_rdata, mem_word(m_addr));
    if (m_dv) check_eq("d_rdata", bus.d_rdata, mem_word(m_addr));
    check_eq("if_stall", bus.if_stall, bus.if_req && !m_fv);
    check_eq("d_stall", bus.d_stall, bus.d_req && !m_dv);
    check_eq("timeout_err", bus.timeout_err, m_err);

    nmreq = 0; nfv = 0; ndv = 0;
    idle_now = (m_busy == 0);
    if (m_busy != 0) begin
      if (bus.mem_ack) begin
        if (m_busy == 1) nfv = 1; else ndv = 1;
        m_busy = 0;
      end
    end else if (!m_fv && !m_dv) begin
      if (bus.d_req && !(bus.if_req && m_wins == SMAX)) begin
        m_busy = 2; nmreq = 1;
        m_addr = bus.d_addr; m_we = bus.d_we; m_size = bus.d_size; m_wdata = bus.d_wdata;
        if (bus.if_req && m_wins < SMAX) m_wins++;
      end else if (bus.if_req) begin
        m_busy = 1; nmreq = 1;
        m_addr = bus.if_addr; m_we = 0; m_size = 2'b10;
        m_wins = 0;
      end
    end
    if (idle_now && !bus.if_req) m_wins = 0;
    m_mreq = nmreq; m_fv = nfv; m_dv = ndv;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) engine_cycle();
  endtask

  task automatic drain();
    p_if = 0; p_d = 0; spur_en = 0;
    run_cycles(25);
  endtask

  task automatic check_starvation();
    int runs, cnt;
    bit seen_f;
    runs = 0; cnt = 0; seen_f = 0;
    foreach (glog[i]) begin
      if (!glog[i]) begin
        if (seen_f) begin
          check_eq("starve_run_len", cnt, SMAX);
          runs++;
        end
        seen_f = 1; cnt = 0;
      end else cnt++;
    end
    check_eq("starve_runs_seen", runs >= 5, 1);
  endtask

  task automatic fetch_plan();
    @(posedge clk); #1 bus.if_req = 1; bus.if_addr = 32'h0000_0040;
    @(negedge clk);
    check_eq("fp_t0_mem_req", bus.mem_req, 0);
    check_eq("fp_t0_stall", bus.if_stall, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("fp_t1_mem_req", bus.mem_req, 1);
    check_eq("fp_t1_mem_addr", bus.mem_addr, 32'h40);
    check_eq("fp_t1_mem_size", bus.mem_size, 2'b10);
    check_eq("fp_t1_mem_we", bus.mem_we, 0);
    check_eq("fp_t1_stall", bus.if_stall, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("fp_t2_mem_req", bus.mem_req, 0);
    check_eq("fp_t2_stall", bus.if_stall, 1);
    @(posedge clk); #1 bus.mem_ack = 1; bus.mem_rdata = 32'h3400_0000;
    @(negedge clk);
    check_eq("fp_t3_valid", bus.if_valid, 0);
    check_eq("fp_t3_stall", bus.if_stall, 1);
    @(posedge clk); #1 bus.mem_ack = 0;
    @(negedge clk);
    check_eq("fp_t4_valid", bus.if_valid, 1);
    check_eq("fp_t4_rdata", bus.if_rdata, 32'h3400_0000);
    check_eq("fp_t4_stall", bus.if_stall, 0);
    @(posedge clk); #1 bus.if_req = 0;
    @(negedge clk);
    check_eq("fp_t5_valid", bus.if_valid, 0);
    check_eq("fp_t5_mem_req", bus.mem_req, 0);
  endtask

  task automatic simultaneous();
    bit found;
    @(posedge clk); #1;
    bus.if_req = 1; bus.if_addr = 32'h0000_0200;
    bus.d_req = 1; bus.d_we = 1; bus.d_size = 2'b10; bus.d_addr = 32'h0000_0100; bus.d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    @(posedge clk); #1 bus.mem_ack = 1; bus.mem_rdata = '0;
    @(negedge clk);
    check_eq("sim_mem_req", bus.mem_req, 1);
    check_eq("sim_mem_we", bus.mem_we, 1);
    check_eq("sim_mem_addr", bus.mem_addr, 32'h100);
    check_eq("sim_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    check_eq("sim_mem_size", bus.mem_size, 2'b10);
    check_eq("sim_if_stall", bus.if_stall, 1);
    @(posedge clk); #1 bus.mem_ack = 0;
    @(negedge clk);
    check_eq("sim_d_valid", bus.d_valid, 1);
    @(posedge clk); #1 bus.d_req = 0; bus.d_we = 0;
    found = 0;
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge clk);
      if (bus.mem_req) begin
        found = 1;
        check_eq("sim_f_addr", bus.mem_addr, 32'h200);
        check_eq("sim_f_we", bus.mem_we, 0);
      end else begin
        @(posedge clk); #1;
      end
    end
    check_eq("sim_fetch_granted", found, 1);
    @(posedge clk); #1 bus.mem_ack = 1; bus.mem_rdata = mem_word(32'h200);
    @(negedge clk);
    @(posedge clk); #1 bus.mem_ack = 0;
    @(negedge clk);
    check_eq("sim_if_valid", bus.if_valid, 1);
    check_eq("sim_if_rdata", bus.if_rdata, mem_word(32'h200));
    @(posedge clk); #1 bus.if_req = 0;
    @(negedge clk);
  endtask

  task automatic timeout_case();
    int start, lat;
    @(posedge clk); #1;
    bus.mem_ack = 0; bus.mem_rdata = 32'hFFFF_FFFF;
    bus.d_req = 1; bus.d_we = 0; bus.d_size = 2'b10; bus.d_addr = 32'h8000_0200;
    start = -1; lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.mem_req && start < 0) start = i;
      if (bus.d_valid) begin
        lat = i - start;
        break;
      end
    end
    check_eq("to_latency", lat, TO);
    check_eq("to_d_rdata", bus.d_rdata, 0);
    check_eq("to_err_set", bus.timeout_err, 1);
    @(posedge clk); #1 bus.d_req = 0;
    @(negedge clk);
    check_eq("to_single_pulse", bus.d_valid, 0);
    check_eq("to_err_sticky", bus.timeout_err, 1);
  endtask

  task automatic reset_mid();
    @(posedge clk); #1;
    bus.d_req = 1; bus.d_we = 0; bus.d_size = 2'b01; bus.d_addr = 32'h8000_0300;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rm_mem_req", bus.mem_req, 1);
    check_eq("rm_mem_size_half", bus.mem_size, 2'b01);
    @(posedge clk); #1 reset = 1; bus.d_req = 0;
    @(negedge clk);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    check_reset_vals("rm_after_rst");
    @(posedge clk); #1 bus.mem_ack = 1; bus.mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check_reset_vals("rm_ack_cycle");
    @(posedge clk); #1 bus.mem_ack = 0;
    @(negedge clk);
    check_reset_vals("rm_post_ack");
    @(posedge clk); #1 bus.if_req = 1; bus.if_addr = 32'h0000_0044;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rm_idle_regrant", bus.mem_req, 1);
    check_eq("rm_idle_addr", bus.mem_addr, 32'h44);
    @(posedge clk); #1 bus.mem_ack = 1; bus.mem_rdata = mem_word(32'h44);
    @(negedge clk);
    @(posedge clk); #1 bus.mem_ack = 0;
    @(negedge clk);
    check_eq("rm_fetch_valid", bus.if_valid, 1);
    check_eq("rm_fetch_rdata", bus.if_rdata, mem_word(32'h44));
    @(posedge clk); #1 bus.if_req = 0;
    @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0;
    p_if = 0; p_d = 0; max_k = 0; spur_en = 0;
    reset = 1;
    drive_quiet();
    engine_init(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst_init");
    @(posedge clk); #1 reset = 0;

    fetch_plan();

    engine_init(0);
    p_if = 40; p_d = 40; max_k = 4; spur_en = 1;
    run_cycles(1500);
    drain();

    glog.delete();
    p_if = 100; p_d = 100; max_k = 0; spur_en = 0;
    run_cycles(240);
    check_starvation();
    drain();

    simultaneous();
    timeout_case();

    engine_init(1);
    p_if = 50; p_d = 50; max_k = 3; spur_en = 1;
    run_cycles(300);
    drain();

    reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
